// File: rtl/mon_pad_scan_seq_if.sv
// Handshake and pad-control bundle for mon_pad_scan_seq.
// The sf_en signal exists only when MON_SCAN_SF_EN is defined.
interface mon_pad_scan_seq_if #(
  parameter int N_CH    = 6,
  parameter int DWELL_W = 16
);
  localparam int CH_W = $clog2(N_CH);

  logic                start;
  logic                stop;
  logic                cont;
  logic [N_CH-1:0]     ch_mask;
  logic [DWELL_W-1:0]  dwell;
  logic [N_CH-1:0]     pa_sel;
  logic [N_CH/2-1:0]   oe;
  logic                sample;
  logic [CH_W-1:0]     ch_id;
  logic                busy;
  logic                done;
  logic                err;
`ifdef MON_SCAN_SF_EN
  logic                sf_en;
`endif

  modport master (
    output start, stop, cont, ch_mask, dwell,
    input  pa_sel, oe, sample, ch_id, busy, done, err
`ifdef MON_SCAN_SF_EN
    , input sf_en
`endif
  );

  modport slave (
    input  start, stop, cont, ch_mask, dwell,
    output pa_sel, oe, sample, ch_id, busy, done, err
`ifdef MON_SCAN_SF_EN
    , output sf_en
`endif
  );
endinterface

// File: rtl/mon_pad_scan_seq.sv
// Time-multiplexed monitor pad scan sequencer with break-before-make channel switching.
// Optional source-follower warm-up phase enabled by defining MON_SCAN_SF_EN.
module mon_pad_scan_seq #(
  parameter int N_CH       = 6,
  parameter int DWELL_W    = 16,
  parameter int SETTLE_CYC = 4,
  parameter int WARM_CYC   = 8
) (
  input  logic               clk,
  input  logic               rst_b,
  mon_pad_scan_seq_if.slave  bus
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int WRM_W = $clog2(WARM_CYC + 1);
  localparam int CNT_W = (DWELL_W >= SET_W && DWELL_W >= WRM_W) ? DWELL_W :
                         ((SET_W >= WRM_W) ? SET_W : WRM_W);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
`ifdef MON_SCAN_SF_EN
    ST_WARM   = 3'd1,
`endif
    ST_SETTLE = 3'd2,
    ST_DWELL  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = {CH_W{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // MSB of the result flags that a higher set bit was found.
  function automatic logic [CH_W:0] next_set(input logic [N_CH-1:0] m,
                                             input logic [CH_W-1:0] cur);
    logic [CH_W:0] res;
    res = {(CH_W+1){1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) res = {1'b1, CH_W'(i)};
    end
    return res;
  endfunction

  function automatic logic [N_CH/2-1:0] pair_oe(input logic [N_CH-1:0] sel);
    logic [N_CH/2-1:0] o;
    for (int k = 0; k < N_CH / 2; k++) begin
      o[k] = sel[2*k] | sel[2*k+1];
    end
    return o;
  endfunction

  state_t              state_r, nxt_state_s;
  logic [CNT_W-1:0]    cnt_r, nxt_cnt_s, dwell_load_s;
  logic [CH_W-1:0]     ch_id_r, nxt_ch_s;
  logic [N_CH-1:0]     mask_r;
  logic [DWELL_W-1:0]  dwell_r;
  logic                cont_r;
  logic                start_ok_s;
  logic                err_s;
  logic [CH_W:0]       nxt_up_s;
  logic [N_CH-1:0]     sel_s;
  logic                busy_s;
  logic                sample_s;
  logic [N_CH-1:0]     pa_sel_r;
  logic [N_CH/2-1:0]   oe_r;
  logic                sample_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;

  // Next-state, counter and channel selection.
  always_comb begin
    nxt_state_s  = state_r;
    nxt_cnt_s    = cnt_r;
    nxt_ch_s     = ch_id_r;
    start_ok_s   = 1'b0;
    err_s        = 1'b0;
    nxt_up_s     = {(CH_W+1){1'b0}};
    if (dwell_r == {DWELL_W{1'b0}}) begin
      dwell_load_s = {CNT_W{1'b0}};
    end else begin
      dwell_load_s = CNT_W'(dwell_r) - CNT_W'(1);
    end
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.ch_mask != {N_CH{1'b0}}) begin
            start_ok_s = 1'b1;
            nxt_ch_s   = lowest_set(bus.ch_mask);
`ifdef MON_SCAN_SF_EN
            nxt_state_s = ST_WARM;
            nxt_cnt_s   = CNT_W'(WARM_CYC - 1);
`else
            nxt_state_s = ST_SETTLE;
            nxt_cnt_s   = CNT_W'(SETTLE_CYC - 1);
`endif
          end else begin
            err_s = 1'b1;
          end
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
`ifdef MON_SCAN_SF_EN
      ST_WARM: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          nxt_state_s = ST_SETTLE;
          nxt_cnt_s   = CNT_W'(SETTLE_CYC - 1);
        end else begin
          nxt_cnt_s = cnt_r - CNT_W'(1);
        end
      end
`endif
      ST_SETTLE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          nxt_state_s = ST_DWELL;
          nxt_cnt_s   = dwell_load_s;
        end else begin
          nxt_cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_DWELL: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          nxt_state_s = ST_NEXT;
        end else begin
          nxt_cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_NEXT: begin
        nxt_up_s = next_set(mask_r, ch_id_r);
        nxt_cnt_s = CNT_W'(SETTLE_CYC - 1);
        if (nxt_up_s[CH_W]) begin
          nxt_state_s = ST_SETTLE;
          nxt_ch_s    = nxt_up_s[CH_W-1:0];
        end else if (cont_r) begin
          nxt_state_s = ST_SETTLE;
          nxt_ch_s    = lowest_set(mask_r);
        end else begin
          nxt_state_s = ST_FIN;
        end
      end
      ST_FIN:  nxt_state_s = ST_IDLE;
      default: nxt_state_s = ST_IDLE;
    endcase
    // Abort overrides every pending transition, including a due sample.
    if (bus.stop && (state_r != ST_IDLE)) begin
      nxt_state_s = ST_IDLE;
    end else begin
      nxt_state_s = nxt_state_s;
    end
  end

  // Output values for the next cycle, decoded from the next state.
  always_comb begin
    sel_s    = {N_CH{1'b0}};
    busy_s   = 1'b0;
    sample_s = 1'b0;
    if ((nxt_state_s == ST_SETTLE) || (nxt_state_s == ST_DWELL)) begin
      sel_s = {{(N_CH-1){1'b0}}, 1'b1} << nxt_ch_s;
    end else begin
      sel_s = {N_CH{1'b0}};
    end
    if ((nxt_state_s == ST_SETTLE) || (nxt_state_s == ST_DWELL) ||
`ifdef MON_SCAN_SF_EN
        (nxt_state_s == ST_WARM) ||
`endif
        (nxt_state_s == ST_NEXT)) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
    if ((nxt_state_s == ST_DWELL) && (nxt_cnt_s == {CNT_W{1'b0}})) begin
      sample_s = 1'b1;
    end else begin
      sample_s = 1'b0;
    end
  end

  // State, counter, latched scan configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      ch_id_r  <= {CH_W{1'b0}};
      mask_r   <= {N_CH{1'b0}};
      dwell_r  <= {DWELL_W{1'b0}};
      cont_r   <= 1'b0;
      pa_sel_r <= {N_CH{1'b0}};
      oe_r     <= {(N_CH/2){1'b0}};
      sample_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= nxt_state_s;
      cnt_r    <= nxt_cnt_s;
      ch_id_r  <= nxt_ch_s;
      if (start_ok_s) begin
        mask_r  <= bus.ch_mask;
        dwell_r <= bus.dwell;
        cont_r  <= bus.cont;
      end
      pa_sel_r <= sel_s;
      oe_r     <= pair_oe(sel_s);
      sample_r <= sample_s;
      busy_r   <= busy_s;
      done_r   <= (nxt_state_s == ST_FIN);
      err_r    <= err_s;
    end
  end

  assign bus.pa_sel = pa_sel_r;
  assign bus.oe     = oe_r;
  assign bus.sample = sample_r;
  assign bus.ch_id  = ch_id_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.err    = err_r;
`ifdef MON_SCAN_SF_EN
  // Source follower tracks BUSY: on from warm-up, off at FIN, STOP or reset.
  assign bus.sf_en  = busy_r;
`endif
endmodule

// File: doc/mon_pad_scan_seq.md
Name: mon_pad_scan_seq

Overview:
- Parametrised successor to the fixed top-pad monitor shell.
- Time-multiplexes N_CH monitor pad channels (PA/OE groups) onto one shared external readout.
- Sequences channel select and pair output-enables with break-before-make, a settle time and a programmable dwell, and strobes a sample request per channel.
- Sits between the global configuration registers and the monitor pad drivers on the chip top.

Parameters:
- N_CH, 6, number of monitor channels; even, 2..32.
- DWELL_W, 16, width of the dwell-length input.
- SETTLE_CYC, 4, cycles a channel is held selected before dwell starts; must be at least 1.
- WARM_CYC, 8, source-follower warm-up cycles; used only with MON_SCAN_SF_EN.

Ports:
- CLK  in  1  block clock
- RST_B  in  1  asynchronous active-low reset
- START  in  1  single-cycle scan start request
- STOP  in  1  abort request
- CONT  in  1  continuous scan mode; sampled at START
- CH_MASK  in  N_CH  channels to scan; sampled at START
- DWELL  in  DWELL_W  dwell length in cycles; sampled at START
- PA_SEL  out  N_CH  one-hot channel select
- OE  out  N_CH/2  pair enable; OE[k] = PA_SEL[2k] | PA_SEL[2k+1]
- SAMPLE  out  1  one-cycle sample strobe
- CH_ID  out  clog2(N_CH)  current channel index
- BUSY  out  1  scan in progress
- DONE  out  1  one-cycle scan-complete pulse
- ERR  out  1  one-cycle pulse: START with empty mask
- SF_EN  out  1  source-follower enable; present only with MON_SCAN_SF_EN

Behaviour:
- Interface: one clock, CLK; reset RST_B, asynchronous, active-low.
- Reset state: IDLE. All outputs 0, including CH_ID. Latched mask, dwell and mode are cleared. Reset asserted mid-scan drops PA_SEL and OE the same instant, with no DONE.
- All outputs are registered.
- States: IDLE, SETTLE, DWELL, NEXT, FIN.
- IDLE, START=1 with CH_MASK!=0:
  - Latch CH_MASK, DWELL and CONT.
  - Load CH_ID with the lowest set bit of the mask and enter SETTLE.
  - PA_SEL, OE and BUSY rise in the cycle after START.
- IDLE, START=1 with CH_MASK==0: ERR pulses for one cycle and the block stays in IDLE.
- START outside IDLE is ignored.
- Changes on CH_MASK, DWELL or CONT during a scan are ignored.
- SETTLE: lasts exactly SETTLE_CYC cycles, then DWELL.
- DWELL:
  - Lasts max(latched DWELL, 1) cycles; DWELL=0 is treated as 1.
  - SAMPLE=1 only in the last DWELL cycle, with CH_ID valid.
- NEXT (one cycle, break-before-make):
  - PA_SEL=0 and OE=0; BUSY stays 1.
  - Selects the next higher set bit in the latched mask and returns to SETTLE.
  - If no higher bit is set and CONT=1: wrap to the lowest set bit and return to SETTLE.
  - If no higher bit is set and CONT=0: go to FIN.
- FIN (one cycle): DONE=1, BUSY=0, then IDLE.
- BUSY is 1 in SETTLE, DWELL and NEXT.
- STOP in any non-IDLE state:
  - Next cycle is IDLE with PA_SEL, OE, BUSY and SAMPLE = 0.
  - No DONE.
  - STOP beats a SAMPLE due in the same cycle.
- STOP and START together in IDLE: no start, no ERR.
- The one-hot invariant holds at all times: at most one PA_SEL bit set.
- Single-bit mask with CONT=1: the one channel is revisited indefinitely, with a one-cycle NEXT gap each pass.

Optional Feature:
- Macro MON_SCAN_SF_EN.
- Defined:
  - Adds the SF_EN port and a WARM state between IDLE and the first SETTLE.
  - WARM lasts WARM_CYC cycles with SF_EN=1, BUSY=1, PA_SEL=0.
  - SF_EN then stays 1 until FIN, STOP or reset. It drops with BUSY, and is never asserted in FIN.
  - CONT wrap does not re-enter WARM.
- Undefined: no SF_EN port, no WARM state; IDLE goes directly to SETTLE.

Test Plan:
- Basic scan. N_CH=6, SETTLE_CYC=4, macro off; START at cycle 0 with CH_MASK=6'b000101, DWELL=3, CONT=0 -> PA_SEL=000001 and OE=001 for cycles 1-7; SAMPLE at cycle 7 with CH_ID=0; cycle 8 all zero; PA_SEL=000100 and OE=010 for cycles 9-15; SAMPLE at cycle 15 with CH_ID=2; DONE at cycle 17; BUSY high for cycles 1-16.
- Empty mask. START with CH_MASK=0 -> ERR for one cycle at cycle 1; BUSY, PA_SEL and DONE stay 0.
- Zero dwell and wrap. CH_MASK=6'b100000, DWELL=0, CONT=1 -> SAMPLE with CH_ID=5 every 6 cycles (4 settle + 1 dwell + 1 NEXT); DONE never asserted.
- Abort. STOP at cycle 6 of the basic scan -> cycle 7 all outputs 0, no SAMPLE, no DONE; a new START at cycle 10 restarts from channel 0.
- Mid-scan changes. CH_MASK changed to 0 and a second START issued at cycle 3 of the basic scan -> ignored; scan completes exactly as in the first scenario.
- Async reset and warm-up. RST_B low at cycle 5 -> PA_SEL, OE and BUSY 0 immediately, with no clock edge needed. With MON_SCAN_SF_EN and WARM_CYC=8 -> SF_EN high from cycle 1; first PA_SEL at cycle 9; SF_EN falls with BUSY.
